// File: rtl/gecko_reg_scoreboard.sv
// gecko_reg_scoreboard: per-register pending-write counters and status for decode hazard checks.
// Rev 1.0 - initial release.
`default_nettype none

package gecko_reg_pkg;
  typedef enum logic [1:0] {
    REG_VALID   = 2'd0,
    REG_PARTIAL = 2'd1,
    REG_FULL    = 2'd2
  } gecko_reg_status_t;
endpackage

module gecko_reg_scoreboard #(
  parameter int COUNTER_WIDTH = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               issue_valid,
  input  logic [4:0]                         issue_addr,
  input  logic                               retire0_valid,
  input  logic [4:0]                         retire0_addr,
  input  logic                               retire1_valid,
  input  logic [4:0]                         retire1_addr,
  output logic [31:0][1:0]                   reg_status,
  output logic [31:0][COUNTER_WIDTH-1:0]     reg_count,
  output logic [5:0]                         busy_regs,
  output logic                               idle,
  output logic                               overflow_err,
  output logic                               underflow_err
);

  localparam int NW = COUNTER_WIDTH + 2;
  localparam logic [COUNTER_WIDTH-1:0] MAX_CNT = '1;
  localparam logic signed [NW-1:0]     MAX_S   = $signed({2'b00, MAX_CNT});

  logic [31:0][COUNTER_WIDTH-1:0] count_q, count_d;
  logic [31:0]                    ovf_hit, unf_hit;
  logic [5:0]                     busy_q, busy_d;
  logic                           idle_q;
  logic                           ovf_q, unf_q;

  // x0 is hardwired: never counts, never flags.
  assign count_d[0] = '0;
  assign ovf_hit[0] = 1'b0;
  assign unf_hit[0] = 1'b0;

  for (genvar r = 1; r < 32; r++) begin : g_reg
    logic                  inc;
    logic [1:0]            dec;
    logic signed [NW-1:0]  sum;

    assign inc = issue_valid && (issue_addr == 5'(r));
    assign dec = {1'b0, retire0_valid && (retire0_addr == 5'(r))}
               + {1'b0, retire1_valid && (retire1_addr == 5'(r))};
    // Two guard bits hold both MAX+1 and -2 without wrapping.
    assign sum = $signed({2'b00, count_q[r]})
               + $signed({{(NW-1){1'b0}}, inc})
               - $signed({{(NW-2){1'b0}}, dec});

    assign unf_hit[r] = sum[NW-1];
    assign ovf_hit[r] = !sum[NW-1] && (sum > MAX_S);
    assign count_d[r] = unf_hit[r] ? '0 :
                        ovf_hit[r] ? MAX_CNT : sum[COUNTER_WIDTH-1:0];
  end

  always_comb begin
    busy_d = '0;
    for (int i = 1; i < 32; i++) begin
      busy_d = busy_d + {5'b0, |count_d[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      busy_q  <= '0;
      idle_q  <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      busy_q  <= busy_d;
      idle_q  <= (busy_d == 6'd0);
      ovf_q   <= ovf_q | (|ovf_hit);
      unf_q   <= unf_q | (|unf_hit);
    end
  end

  for (genvar r = 0; r < 32; r++) begin : g_status
    assign reg_status[r] = (count_q[r] == '0)     ? gecko_reg_pkg::REG_VALID :
                           (count_q[r] == MAX_CNT) ? gecko_reg_pkg::REG_FULL :
                                                     gecko_reg_pkg::REG_PARTIAL;
  end

  assign reg_count     = count_q;
  assign busy_regs     = busy_q;
  assign idle          = idle_q;
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;

endmodule

`default_nettype wire

// File: tb/tb_gecko_reg_scoreboard.sv
// Directed and model-checked random bench for gecko_reg_scoreboard (COUNTER_WIDTH=2).
`default_nettype none

module tb_gecko_reg_scoreboard;
  localparam int CW = 2;
  localparam int MAXV = 3;
  localparam logic [1:0] ST_VALID = 2'd0, ST_PARTIAL = 2'd1, ST_FULL = 2'd2;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   issue_valid = 1'b0;
  logic [4:0]             issue_addr = '0;
  logic                   retire0_valid = 1'b0;
  logic [4:0]             retire0_addr = '0;
  logic                   retire1_valid = 1'b0;
  logic [4:0]             retire1_addr = '0;
  logic [31:0][1:0]       reg_status;
  logic [31:0][CW-1:0]    reg_count;
  logic [5:0]             busy_regs;
  logic                   idle;
  logic                   overflow_err;
  logic                   underflow_err;

  int n_checks = 0;
  int n_fail = 0;

  gecko_reg_scoreboard #(.COUNTER_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .retire0_valid(retire0_valid), .retire0_addr(retire0_addr),
    .retire1_valid(retire1_valid), .retire1_addr(retire1_addr),
    .reg_status(reg_status), .reg_count(reg_count), .busy_regs(busy_regs),
    .idle(idle), .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    issue_valid = 1'b0; retire0_valid = 1'b0; retire1_valid = 1'b0;
  endtask

  task automatic drive(input logic iv, input logic [4:0] ia, input logic r0v,
                       input logic [4:0] r0a, input logic r1v, input logic [4:0] r1a);
    issue_valid = iv; issue_addr = ia;
    retire0_valid = r0v; retire0_addr = r0a;
    retire1_valid = r1v; retire1_addr = r1a;
    step();
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 5'd0);
    drive(1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 5'd0);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      issue_valid = 1'($urandom); issue_addr = 5'($urandom_range(0, 31));
      retire0_valid = 1'($urandom); retire0_addr = 5'($urandom_range(0, 31));
      retire1_valid = 1'($urandom); retire1_addr = 5'($urandom_range(0, 31));
      step();
    end
    n_checks++;
    if (reg_status !== '0) begin n_fail++; $display("FAIL reset_status actual=%h required=0", reg_status); end
    n_checks++;
    if (reg_count !== '0) begin n_fail++; $display("FAIL reset_count actual=%h required=0", reg_count); end
    n_checks++;
    if (busy_regs !== 6'd0) begin n_fail++; $display("FAIL reset_busy actual=%0d required=0", busy_regs); end
    n_checks++;
    if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle actual=%b required=1", idle); end
    n_checks++;
    if ({overflow_err, underflow_err} !== 2'b00) begin
      n_fail++; $display("FAIL reset_errs actual=%b%b required=00", overflow_err, underflow_err);
    end
    rst = 1'b1;
  endtask

  task automatic test_fill();
    logic [1:0] exp_st [3] = '{ST_PARTIAL, ST_PARTIAL, ST_FULL};
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
      n_checks++;
      if (reg_count[5] !== 2'(k + 1)) begin
        n_fail++; $display("FAIL fill_count step=%0d actual=%0d required=%0d", k, reg_count[5], k + 1);
      end
      n_checks++;
      if (reg_status[5] !== exp_st[k]) begin
        n_fail++; $display("FAIL fill_status step=%0d actual=%0d required=%0d", k, reg_status[5], exp_st[k]);
      end
    end
    n_checks++;
    if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL fill_noovf actual=%b required=0", overflow_err); end
    drive(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
    n_checks++;
    if (reg_count[5] !== 2'd3) begin n_fail++; $display("FAIL fill_sat actual=%0d required=3", reg_count[5]); end
    n_checks++;
    if (overflow_err !== 1'b1) begin n_fail++; $display("FAIL fill_ovf actual=%b required=1", overflow_err); end
    n_checks++;
    if (busy_regs !== 6'd1 || idle !== 1'b0) begin
      n_fail++; $display("FAIL fill_busy actual=%0d/%b required=1/0", busy_regs, idle);
    end
  endtask

  task automatic test_release();
    drive(1'b0, 5'd0, 1'b1, 5'd5, 1'b1, 5'd5);
    n_checks++;
    if (reg_count[5] !== 2'd1 || reg_status[5] !== ST_PARTIAL) begin
      n_fail++; $display("FAIL release_dual actual=%0d/%0d required=1/%0d", reg_count[5], reg_status[5], ST_PARTIAL);
    end
    n_checks++;
    if (underflow_err !== 1'b0) begin n_fail++; $display("FAIL release_nounf actual=%b required=0", underflow_err); end
    drive(1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 5'd0);
    n_checks++;
    if (reg_count[5] !== 2'd0 || reg_status[5] !== ST_VALID) begin
      n_fail++; $display("FAIL release_last actual=%0d/%0d required=0/%0d", reg_count[5], reg_status[5], ST_VALID);
    end
    n_checks++;
    if (idle !== 1'b1 || busy_regs !== 6'd0) begin
      n_fail++; $display("FAIL release_idle actual=%b/%0d required=1/0", idle, busy_regs);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int k = 0; k < 3; k++) drive(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0);
    drive(1'b1, 5'd7, 1'b1, 5'd7, 1'b0, 5'd0);
    n_checks++;
    if (reg_count[7] !== 2'd3 || reg_status[7] !== ST_FULL) begin
      n_fail++; $display("FAIL netzero_count actual=%0d/%0d required=3/%0d", reg_count[7], reg_status[7], ST_FULL);
    end
    n_checks++;
    if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL netzero_ovf actual=%b required=0", overflow_err); end
    drive(1'b1, 5'd12, 1'b1, 5'd7, 1'b0, 5'd0);
    n_checks++;
    if (reg_count[7] !== 2'd2 || reg_count[12] !== 2'd1 || busy_regs !== 6'd2) begin
      n_fail++; $display("FAIL b2b_mix actual=%0d/%0d/%0d required=2/1/2", reg_count[7], reg_count[12], busy_regs);
    end
  endtask

  task automatic test_x0_underflow();
    apply_reset();
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0);
    n_checks++;
    if (reg_count !== '0 || reg_status[0] !== ST_VALID || idle !== 1'b1) begin
      n_fail++; $display("FAIL x0_ignore actual=%h/%b required=0/1", reg_count, idle);
    end
    n_checks++;
    if ({overflow_err, underflow_err} !== 2'b00) begin
      n_fail++; $display("FAIL x0_errs actual=%b%b required=00", overflow_err, underflow_err);
    end
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9);
    n_checks++;
    if (reg_count[9] !== 2'd0 || underflow_err !== 1'b1 || overflow_err !== 1'b0) begin
      n_fail++; $display("FAIL underflow actual=%0d/%b/%b required=0/1/0", reg_count[9], underflow_err, overflow_err);
    end
    drive(1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0);
    n_checks++;
    if (reg_count[3] !== 2'd1 || underflow_err !== 1'b1 || busy_regs !== 6'd1) begin
      n_fail++; $display("FAIL after_err actual=%0d/%b/%0d required=1/1/1", reg_count[3], underflow_err, busy_regs);
    end
  endtask

  task automatic test_random();
    int m [32];
    logic [31:0][CW-1:0] exp_cnt;
    int exp_busy, prints, nv, dec;
    logic iv, r0v, r1v;
    logic [4:0] ia, r0a, r1a;
    apply_reset();
    for (int r = 0; r < 32; r++) m[r] = 0;
    prints = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      ia = 5'($urandom_range(0, 31));
      r0a = 5'($urandom_range(0, 31));
      r1a = 5'($urandom_range(0, 31));
      iv = 1'($urandom) && (m[ia] < MAXV);
      r0v = 1'($urandom) && (m[r0a] > 0);
      r1v = 1'($urandom) && (m[r1a] > ((r0v && r0a == r1a) ? 1 : 0));
      exp_busy = 0;
      for (int r = 1; r < 32; r++) begin
        dec = ((r0v && r0a == 5'(r)) ? 1 : 0) + ((r1v && r1a == 5'(r)) ? 1 : 0);
        nv = m[r] + ((iv && ia == 5'(r)) ? 1 : 0) - dec;
        m[r] = (nv < 0) ? 0 : (nv > MAXV) ? MAXV : nv;
        if (m[r] != 0) exp_busy++;
      end
      for (int r = 0; r < 32; r++) exp_cnt[r] = CW'(m[r]);
      drive(iv, ia, r0v, r0a, r1v, r1a);
      n_checks++;
      if (reg_count !== exp_cnt || busy_regs !== 6'(exp_busy) || idle !== (exp_busy == 0)) begin
        n_fail++;
        if (prints < 10) begin
          prints++;
          $display("FAIL random cyc=%0d count=%h busy=%0d required count=%h busy=%0d",
                   cyc, reg_count, busy_regs, exp_cnt, exp_busy);
        end
      end
    end
    n_checks++;
    if ({overflow_err, underflow_err} !== 2'b00) begin
      n_fail++; $display("FAIL random_errs actual=%b%b required=00", overflow_err, underflow_err);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_fill();
    test_release();
    test_back_to_back();
    test_x0_underflow();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
